code_entry_checker: RTL and testbench

//   Sequential successor to the combinational code comparator. Collects a PIN one digit
//   per handshake, compares the assembled code against stored_code, and reports match or

---
 rtl/code_entry_checker.sv | 178 +++++++++++++++++
 tb/tb_code_entry_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_checker.sv
// code_entry_checker
//   Collects a PIN one digit per handshake, compares the assembled code against
//   i_stored_code and pulses o_match or o_mismatch. Consecutive mismatches are counted;
//   reaching MAX_ATTEMPTS starts a lockout lasting LOCKOUT_CYCLES clocks.
//
//   Optional feature: define DIGIT_TIMEOUT_EN to discard a partial entry after
//   TIMEOUT_CYCLES idle cycles. Without it, a partial entry is held indefinitely.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_digit_valid    i_digit_in is valid this cycle
//   i_digit_in       entered digit (DIGIT_W bits)
//   i_clear          discard the partial entry
//   i_stored_code    reference code, first digit in the MSBs
//   o_match          1-cycle pulse, code correct
//   o_mismatch       1-cycle pulse, code wrong
//   o_locked_out     lockout active
//   o_busy           high unless collecting digits
//   o_digit_count    digits held in the current entry
//   o_attempts_left  tries left before lockout

module code_entry_checker #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_digit_valid,
  input  logic [DIGIT_W-1:0]                    i_digit_in,
  input  logic                                  i_clear,
  input  logic [DIGIT_W*NUM_DIGITS-1:0]         i_stored_code,
  output logic                                  o_match,
  output logic                                  o_mismatch,
  output logic                                  o_locked_out,
  output logic                                  o_busy,
  output logic [$clog2(NUM_DIGITS+1)-1:0]       o_digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     o_attempts_left
);

  localparam int unsigned CodeW = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CntW  = $clog2(NUM_DIGITS + 1);
  localparam int unsigned AttW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned LockW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CntW-1:0]  LastDigit   = CntW'(NUM_DIGITS - 1);
  localparam logic [AttW-1:0]  MaxAttempts = AttW'(MAX_ATTEMPTS);
  localparam logic [LockW-1:0] LockLast    = LockW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StCheck   = 2'd1,
    StLockout = 2'd2
  } state_e;

  state_e           r_state;
  logic [CodeW-1:0] r_entry;
  logic [CntW-1:0]  r_digit_count;
  logic [AttW-1:0]  r_attempts;
  logic [LockW-1:0] r_lock_cnt;
  logic             r_match;
  logic             r_mismatch;
  logic             r_locked;

`ifdef DIGIT_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
  logic [ToW-1:0] r_to_cnt;
`else
  // Timer not built; parameter kept so both builds share one interface.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // New digit enters at the LSBs, so the first digit ends up in the MSBs.
  logic [CodeW-1:0] w_entry_shifted;
  assign w_entry_shifted = (r_entry << DIGIT_W) | CodeW'(i_digit_in);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= StCollect;
      r_entry       <= '0;
      r_digit_count <= '0;
      r_attempts    <= MaxAttempts;
      r_lock_cnt    <= '0;
      r_match       <= 1'b0;
      r_mismatch    <= 1'b0;
      r_locked      <= 1'b0;
`ifdef DIGIT_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      // Result outputs are single-cycle pulses.
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;

      case (r_state)
        StCollect: begin
          if (i_clear) begin
            r_entry       <= '0;
            r_digit_count <= '0;
`ifdef DIGIT_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
          end else if (i_digit_valid) begin
            r_entry <= w_entry_shifted;
`ifdef DIGIT_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            if (r_digit_count == LastDigit) begin
              r_digit_count <= '0;
              r_state       <= StCheck;
            end else begin
              r_digit_count <= r_digit_count + 1'b1;
            end
          end
`ifdef DIGIT_TIMEOUT_EN
          else if (r_digit_count != '0) begin
            if (r_to_cnt == ToLast) begin
              r_entry       <= '0;
              r_digit_count <= '0;
              r_to_cnt      <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
`endif
        end

        StCheck: begin
          r_entry <= '0;
          if (r_entry == i_stored_code) begin
            r_match    <= 1'b1;
            r_attempts <= MaxAttempts;
            r_state    <= StCollect;
          end else begin
            r_mismatch <= 1'b1;
            r_attempts <= r_attempts - 1'b1;
            if (r_attempts == AttW'(1)) begin
              r_locked   <= 1'b1;
              r_lock_cnt <= LockLast;
              r_state    <= StLockout;
            end else begin
              r_state <= StCollect;
            end
          end
        end

        StLockout: begin
          // locked_out was raised on entry; it counts LOCKOUT_CYCLES cycles in total.
          if (r_lock_cnt == '0) begin
            r_locked   <= 1'b0;
            r_attempts <= MaxAttempts;
            r_state    <= StCollect;
          end else begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= StCollect;
          r_entry <= '0;
        end
      endcase
    end
  end

  assign o_match         = r_match;
  assign o_mismatch      = r_mismatch;
  assign o_locked_out    = r_locked;
  assign o_busy          = (r_state != StCollect);
  assign o_digit_count   = r_digit_count;
  assign o_attempts_left = r_attempts;

endmodule

// File: tb/tb_code_entry_checker.sv
// Directed, table-driven bench for code_entry_checker (4x4-bit digits, 3 attempts,
// 20-cycle lockout, 10-cycle digit timeout when DIGIT_TIMEOUT_EN is defined).

module tb_code_entry_checker;

  logic        clk;
  logic        rst_n;
  logic        digit_valid;
  logic [3:0]  digit_in;
  logic        clear;
  logic [15:0] stored_code;
  logic        match;
  logic        mismatch;
  logic        locked_out;
  logic        busy;
  logic [2:0]  digit_count;
  logic [1:0]  attempts_left;

  int checks = 0;
  int errors = 0;

  code_entry_checker #(
    .DIGIT_W       (4),
    .NUM_DIGITS    (4),
    .MAX_ATTEMPTS  (3),
    .LOCKOUT_CYCLES(20),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_digit_valid  (digit_valid),
    .i_digit_in     (digit_in),
    .i_clear        (clear),
    .i_stored_code  (stored_code),
    .o_match        (match),
    .o_mismatch     (mismatch),
    .o_locked_out   (locked_out),
    .o_busy         (busy),
    .o_digit_count  (digit_count),
    .o_attempts_left(attempts_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {match, mismatch, locked_out, busy, digit_count[2:0], attempts[1:0]}
  typedef struct {
    logic        rst_n;
    logic        dv;
    logic        clr;
    logic [3:0]  dig;
    logic [15:0] stored;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] pack(input logic m, input logic mm, input logic lo,
                                      input logic bz, input int cnt, input int att);
    logic [2:0] c;
    logic [1:0] a;
    c = 3'(cnt);
    a = 2'(att);
    return {m, mm, lo, bz, c, a};
  endfunction

  task automatic add(input logic r, input logic dv, input logic clr, input int dig,
                     input logic [15:0] st, input logic m, input logic mm, input logic lo,
                     input logic bz, input int cnt, input int att);
    vec_t v;
    v.rst_n  = r;
    v.dv     = dv;
    v.clr    = clr;
    v.dig    = 4'(dig);
    v.stored = st;
    v.exp    = pack(m, mm, lo, bz, cnt, att);
    vecs.push_back(v);
  endtask

  // Apply inputs, let one rising edge pass, then settle before sampling.
  task automatic tick(input logic r, input logic dv, input logic clr, input int dig);
    rst_n       = r;
    digit_valid = dv;
    clear       = clr;
    digit_in    = 4'(dig);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {match, mismatch, locked_out, busy, digit_count, attempts_left};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got m=%b mm=%b lo=%b busy=%b cnt=%0d att=%0d, want m=%b mm=%b lo=%b busy=%b cnt=%0d att=%0d",
               name, act[8], act[7], act[6], act[5], act[4:2], act[1:0],
               exp[8], exp[7], exp[6], exp[5], exp[4:2], exp[1:0]);
    end
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    tick(1, 1, 0, d0);
    tick(1, 1, 0, d1);
    tick(1, 1, 0, d2);
    tick(1, 1, 0, d3);
    tick(1, 0, 0, 0);  // CHECK edge; result visible afterwards
  endtask

  initial begin
    rst_n       = 1'b0;
    digit_valid = 1'b0;
    clear       = 1'b0;
    digit_in    = 4'h0;
    stored_code = 16'h1234;

    // Reset, including reset winning over active inputs
    add(0, 0, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 3);
    add(0, 1, 1, 5, 16'h1234, 0, 0, 0, 0, 0, 3);
    // Correct code 1,2,3,4
    add(1, 1, 0, 1, 16'h1234, 0, 0, 0, 0, 1, 3);
    add(1, 1, 0, 2, 16'h1234, 0, 0, 0, 0, 2, 3);
    add(1, 1, 0, 3, 16'h1234, 0, 0, 0, 0, 3, 3);
    add(1, 1, 0, 4, 16'h1234, 0, 0, 0, 1, 0, 3);
    add(1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 3);
    // Clear together with digit 3 drops the digit; then a clean 1,2,3,4
    add(1, 1, 0, 1, 16'h1234, 0, 0, 0, 0, 1, 3);
    add(1, 1, 0, 2, 16'h1234, 0, 0, 0, 0, 2, 3);
    add(1, 1, 1, 3, 16'h1234, 0, 0, 0, 0, 0, 3);
    add(1, 1, 0, 1, 16'h1234, 0, 0, 0, 0, 1, 3);
    add(1, 1, 0, 2, 16'h1234, 0, 0, 0, 0, 2, 3);
    add(1, 1, 0, 3, 16'h1234, 0, 0, 0, 0, 3, 3);
    add(1, 1, 0, 4, 16'h1234, 0, 0, 0, 1, 0, 3);
    add(1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 3);
    // Clear alone
    add(1, 1, 0, 9, 16'h1234, 0, 0, 0, 0, 1, 3);
    add(1, 0, 1, 0, 16'h1234, 0, 0, 0, 0, 0, 3);
    // Wrong code 2,4,5,8; digit offered during CHECK is ignored
    add(1, 1, 0, 2, 16'h1234, 0, 0, 0, 0, 1, 3);
    add(1, 1, 0, 4, 16'h1234, 0, 0, 0, 0, 2, 3);
    add(1, 1, 0, 5, 16'h1234, 0, 0, 0, 0, 3, 3);
    add(1, 1, 0, 8, 16'h1234, 0, 0, 0, 1, 0, 3);
    add(1, 1, 0, 9, 16'h1234, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 2);
    // Leading-zero code 0,0,0,7; match reloads attempts
    add(1, 1, 0, 0, 16'h0007, 0, 0, 0, 0, 1, 2);
    add(1, 1, 0, 0, 16'h0007, 0, 0, 0, 0, 2, 2);
    add(1, 1, 0, 0, 16'h0007, 0, 0, 0, 0, 3, 2);
    add(1, 1, 0, 7, 16'h0007, 0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 0, 16'h0007, 1, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 16'h0007, 0, 0, 0, 0, 0, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      stored_code = vecs[i].stored;
      tick(vecs[i].rst_n, vecs[i].dv, vecs[i].clr, int'(vecs[i].dig));
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Three wrong codes lead to a 20-cycle lockout that ignores digits
    stored_code = 16'h1234;
    enter_code(5, 5, 5, 5);
    check("wrong1", pack(0, 1, 0, 0, 0, 2));
    enter_code(5, 5, 5, 5);
    check("wrong2", pack(0, 1, 0, 0, 0, 1));
    enter_code(5, 5, 5, 5);
    check("wrong3_lock", pack(0, 1, 1, 1, 0, 0));
    for (int k = 1; k < 20; k++) begin
      tick(1, 1, 0, 1);
      check($sformatf("lock_hold%0d", k), pack(0, 0, 1, 1, 0, 0));
    end
    tick(1, 1, 0, 1);
    check("lock_end", pack(0, 0, 0, 0, 0, 3));
    tick(1, 0, 0, 0);
    check("post_lock_idle", pack(0, 0, 0, 0, 0, 3));
    enter_code(1, 2, 3, 4);
    check("post_lock_match", pack(1, 0, 0, 0, 0, 3));

    // Reset in the middle of a lockout
    enter_code(9, 9, 9, 9);
    enter_code(9, 9, 9, 9);
    enter_code(9, 9, 9, 9);
    check("lock_again", pack(0, 1, 1, 1, 0, 0));
    for (int k = 0; k < 5; k++) tick(1, 0, 0, 0);
    tick(0, 1, 1, 3);
    check("rst_in_lock", pack(0, 0, 0, 0, 0, 3));
    tick(1, 0, 0, 0);
    check("rst_release", pack(0, 0, 0, 0, 0, 3));
    enter_code(1, 2, 3, 4);
    check("post_rst_match", pack(1, 0, 0, 0, 0, 3));

`ifdef DIGIT_TIMEOUT_EN
    // Partial entry discarded after 10 idle cycles, not one earlier
    tick(1, 1, 0, 1);
    for (int k = 0; k < 9; k++) tick(1, 0, 0, 0);
    check("to_before", pack(0, 0, 0, 0, 1, 3));
    tick(1, 0, 0, 0);
    check("to_expired", pack(0, 0, 0, 0, 0, 3));
    enter_code(1, 2, 3, 4);
    check("to_match", pack(1, 0, 0, 0, 0, 3));
`else
    // Partial entry is held indefinitely
    tick(1, 1, 0, 1);
    for (int k = 0; k < 15; k++) tick(1, 0, 0, 0);
    check("hold_partial", pack(0, 0, 0, 0, 1, 3));
    tick(1, 0, 1, 0);
    check("hold_clear", pack(0, 0, 0, 0, 0, 3));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
